// File: rtl/sensor_reader.sv
// Round-robin reader for three 3-axis sensors: fetches X/Y/Z of the granted
// sensor, acknowledges its ready flag, then offers one packet downstream.
module sensor_reader #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              acc_ready,
  input  logic              gyro_ready,
  input  logic              mag_ready,
  output logic              acc_read,
  output logic              gyro_read,
  output logic              mag_read,
  output logic [1:0]        sensor_sel,
  output logic [1:0]        axis_sel,
  input  logic [DATA_W-1:0] sensor_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_id,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z,
  output logic [7:0]        out_seq,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FETCH_X, FETCH_Y, FETCH_Z, ACK, SEND} state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        sensor_sel_q, sensor_sel_d;
  logic [1:0]        axis_sel_q, axis_sel_d;
  logic [1:0]        out_id_q, out_id_d;
  logic [DATA_W-1:0] out_x_q, out_x_d;
  logic [DATA_W-1:0] out_y_q, out_y_d;
  logic [DATA_W-1:0] out_z_q, out_z_d;
  logic [7:0]        out_seq_q, out_seq_d;

  logic [2:0] ready_vec;
  logic [1:0] rr_start;
  logic [1:0] cand;
  logic [1:0] pick;
  logic       pick_found;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign ready_vec = {mag_ready, gyro_ready, acc_ready};

  // Search begins one past the last sensor served; scanning from the far end
  // lets the nearest ready candidate overwrite the others.
  always_comb begin
    rr_start   = wrap3({1'b0, last_q} + 3'd1);
    cand       = rr_start;
    pick       = rr_start;
    pick_found = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      cand = wrap3({1'b0, rr_start} + 3'(k));
      if (ready_vec[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_q       <= 2'd2;
      sensor_sel_q <= 2'd0;
      axis_sel_q   <= 2'd0;
      out_id_q     <= 2'd0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_z_q      <= '0;
      out_seq_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      sensor_sel_q <= sensor_sel_d;
      axis_sel_q   <= axis_sel_d;
      out_id_q     <= out_id_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_z_q      <= out_z_d;
      out_seq_q    <= out_seq_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    sensor_sel_d = sensor_sel_q;
    axis_sel_d   = axis_sel_q;
    out_id_d     = out_id_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_z_d      = out_z_q;
    out_seq_d    = out_seq_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d      = pick;
          sensor_sel_d = pick;
          axis_sel_d   = 2'd0;
          state_d      = FETCH_X;
        end
      end
      FETCH_X: begin
        out_x_d    = sensor_data;
        axis_sel_d = 2'd1;
        state_d    = FETCH_Y;
      end
      FETCH_Y: begin
        out_y_d    = sensor_data;
        axis_sel_d = 2'd2;
        state_d    = FETCH_Z;
      end
      FETCH_Z: begin
        out_z_d = sensor_data;
        state_d = ACK;
      end
      ACK: begin
        out_id_d = grant_q;
        state_d  = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_seq_d = out_seq_q + 8'd1;
          last_d    = grant_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with n_rst suppresses the acknowledge in a cycle where reset is asserted.
  assign acc_read   = n_rst && (state_q == ACK) && (grant_q == 2'd0);
  assign gyro_read  = n_rst && (state_q == ACK) && (grant_q == 2'd1);
  assign mag_read   = n_rst && (state_q == ACK) && (grant_q == 2'd2);

  assign sensor_sel = sensor_sel_q;
  assign axis_sel   = axis_sel_q;
  assign out_valid  = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign out_id     = out_id_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_z      = out_z_q;
  assign out_seq    = out_seq_q;

endmodule

// File: tb/tb_sensor_reader.sv
// Scoreboard bench for sensor_reader: expected packets are queued as flags
// are raised and popped as the reader offers them downstream.
module tb_sensor_reader;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
    logic [7:0]    seq;
  } pkt_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          acc_ready, gyro_ready, mag_ready;
  logic          acc_read, gyro_read, mag_read;
  logic [1:0]    sensor_sel, axis_sel;
  logic [DW-1:0] sensor_data;
  logic          out_valid, out_ready;
  logic [1:0]    out_id;
  logic [DW-1:0] out_x, out_y, out_z;
  logic [7:0]    out_seq;
  logic          busy;

  logic [DW-1:0] data_tab [4][4];
  pkt_t          exp_q[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb sensor_data = data_tab[sensor_sel][axis_sel];

  sensor_reader #(.DATA_W(DW)) dut (
    .clk(clk), .n_rst(n_rst),
    .acc_ready(acc_ready), .gyro_ready(gyro_ready), .mag_ready(mag_ready),
    .acc_read(acc_read), .gyro_read(gyro_read), .mag_read(mag_read),
    .sensor_sel(sensor_sel), .axis_sel(axis_sel), .sensor_data(sensor_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_seq(out_seq), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_data(input int s, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    data_tab[s][0] = x;
    data_tab[s][1] = y;
    data_tab[s][2] = z;
  endtask

  task automatic push_pkt(input logic [1:0] id, input logic [7:0] seq);
    pkt_t p;
    p.id  = id;
    p.x   = data_tab[id][0];
    p.y   = data_tab[id][1];
    p.z   = data_tab[id][2];
    p.seq = seq;
    exp_q.push_back(p);
  endtask

  function automatic logic [31:0] reads_vec();
    return {29'd0, mag_read, gyro_read, acc_read};
  endfunction

  task automatic do_reset();
    acc_ready  = 1'b0;
    gyro_ready = 1'b0;
    mag_ready  = 1'b0;
    out_ready  = 1'b1;
    n_rst      = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(out_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_reads", reads_vec(), 0);
    check_val("rst_sensor_sel", 32'(sensor_sel), 0);
    check_val("rst_axis_sel", 32'(axis_sel), 0);
    check_val("rst_out_id", 32'(out_id), 0);
    check_val("rst_out_xyz", 32'(out_x | out_y | out_z), 0);
    check_val("rst_out_seq", 32'(out_seq), 0);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a read pulse, checks it is the expected one-hot, drops that flag.
  task automatic wait_read(input int s);
    int n = 0;
    while (reads_vec() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_val($sformatf("read_pulse_s%0d", s), reads_vec(), 32'(1 << s));
    case (s)
      0:       acc_ready  = 1'b0;
      1:       gyro_ready = 1'b0;
      default: mag_ready  = 1'b0;
    endcase
  endtask

  task automatic recv_pkt(output int at_cyc);
    pkt_t e;
    int   n = 0;
    at_cyc = -1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check_val("pkt_timeout", 32'(out_valid), 1);
      return;
    end
    at_cyc = cyc;
    if (exp_q.size() == 0) begin
      check_val("pkt_unexpected", 32'(out_valid), 0);
    end else begin
      e = exp_q.pop_front();
      check_val("pkt_id", 32'(out_id), 32'(e.id));
      check_val("pkt_x", 32'(out_x), 32'(e.x));
      check_val("pkt_y", 32'(out_y), 32'(e.y));
      check_val("pkt_z", 32'(out_z), 32'(e.z));
      check_val("pkt_seq", 32'(out_seq), 32'(e.seq));
    end
    $display("packet id=%0d x=%04h y=%04h z=%04h seq=%0d at cycle %0d", out_id, out_x, out_y, out_z, out_seq, cyc);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, prev;
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 4; a++)
        data_tab[s][a] = 16'(16'hE000 + s * 16 + a);
    n_rst = 1'b0;
    acc_ready = 1'b0; gyro_ready = 1'b0; mag_ready = 1'b0; out_ready = 1'b1;

    // Single gyro packet with exact latency, then backpressure.
    do_reset();
    set_data(1, 16'h1111, 16'h2222, 16'h3333);
    push_pkt(2'd1, 8'd0);
    out_ready  = 1'b0;
    gyro_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_val($sformatf("lat_busy_k%0d", k), 32'(busy), 1);
      check_val($sformatf("lat_reads_k%0d", k), reads_vec(), (k == 4) ? 32'd2 : 32'd0);
      check_val($sformatf("lat_valid_k%0d", k), 32'(out_valid), (k == 5) ? 32'd1 : 32'd0);
      if (k <= 3) begin
        check_val($sformatf("lat_sensor_sel_k%0d", k), 32'(sensor_sel), 1);
        check_val($sformatf("lat_axis_sel_k%0d", k), 32'(axis_sel), 32'(k - 1));
      end
      if (k == 4) gyro_ready = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      check_val("bp_valid", 32'(out_valid), 1);
      check_val("bp_id", 32'(out_id), 32'(exp_q[0].id));
      check_val("bp_x", 32'(out_x), 32'(exp_q[0].x));
      check_val("bp_y", 32'(out_y), 32'(exp_q[0].y));
      check_val("bp_z", 32'(out_z), 32'(exp_q[0].z));
      check_val("bp_seq", 32'(out_seq), 32'(exp_q[0].seq));
      check_val("bp_reads", reads_vec(), 0);
      check_val("bp_sel_hold", 32'({sensor_sel, axis_sel}), 32'h6);
      if (i == 2) acc_ready = 1'b1;
      if (i == 8) acc_ready = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    recv_pkt(c);
    check_val("post_send_valid", 32'(out_valid), 0);
    check_val("post_send_busy", 32'(busy), 0);
    check_val("post_send_seq", 32'(out_seq), 1);

    // All three flags held: ids rotate 0,1,2 every 6 cycles.
    do_reset();
    set_data(0, 16'hA001, 16'hA002, 16'hA003);
    set_data(1, 16'hB001, 16'hB002, 16'hB003);
    set_data(2, 16'hC001, 16'hC002, 16'hC003);
    for (int i = 0; i < 6; i++) push_pkt(2'(i % 3), 8'(i));
    acc_ready = 1'b1; gyro_ready = 1'b1; mag_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      recv_pkt(c);
      if (i > 0) check_val("rr_spacing", 32'(c - prev), 6);
      prev = c;
    end
    acc_ready = 1'b0; gyro_ready = 1'b0; mag_ready = 1'b0;
    @(negedge clk);
    check_val("rr_idle_busy", 32'(busy), 0);

    // Fairness: after mag is served, acc wins over mag.
    do_reset();
    push_pkt(2'd2, 8'd0);
    mag_ready = 1'b1;
    wait_read(2);
    recv_pkt(c);
    push_pkt(2'd0, 8'd1);
    push_pkt(2'd2, 8'd2);
    acc_ready = 1'b1;
    mag_ready = 1'b1;
    wait_read(0);
    recv_pkt(c);
    wait_read(2);
    recv_pkt(c);

    // Reset during FETCH_Y abandons the packet; gyro is served afterwards.
    do_reset();
    set_data(1, 16'hBEE1, 16'hBEE2, 16'hBEE3);
    gyro_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("mr_axis_y", 32'(axis_sel), 1);
    check_val("mr_busy", 32'(busy), 1);
    n_rst = 1'b0;
    @(negedge clk);
    check_val("mr_state_idle", 32'(busy), 0);
    check_val("mr_valid", 32'(out_valid), 0);
    check_val("mr_reads", reads_vec(), 0);
    n_rst = 1'b1;
    push_pkt(2'd1, 8'd0);
    wait_read(1);
    recv_pkt(c);

    // Sequence number wraps 255 -> 0.
    do_reset();
    set_data(0, 16'h5A01, 16'h5A02, 16'h5A03);
    for (int i = 0; i < 257; i++) push_pkt(2'd0, 8'(i));
    acc_ready = 1'b1;
    for (int i = 0; i < 257; i++) recv_pkt(c);
    acc_ready = 1'b0;
    check_val("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_reader.md
SENSOR_READER -- requirements
Module: sensor_reader

Interface
REQ-001 Parameter DATA_W, default 16, width of one axis sample.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-low, sampled on rising edge of clk.
REQ-004 acc_ready, gyro_ready, mag_ready  input  1 each  held "new sample available" flags from sensor interface output stage.
REQ-005 acc_read, gyro_read, mag_read  output  1 each  one-cycle pulses that clear the matching ready flag.
REQ-006 sensor_sel  output  2  sensor being fetched: 0=acc, 1=gyro, 2=mag; 3 never driven.
REQ-007 axis_sel  output  2  axis being fetched: 0=X, 1=Y, 2=Z; 3 never driven.
REQ-008 sensor_data  input  DATA_W  sample for {sensor_sel, axis_sel}, valid combinationally in the same cycle.
REQ-009 out_valid  output  1  packet available; out_ready  input  1  downstream accepts.
REQ-010 out_id  output  2  sensor code of packet; out_x, out_y, out_z  output  DATA_W each  captured axes.
REQ-011 out_seq  output  8  packet sequence number; busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, FETCH_X, FETCH_Y, FETCH_Z, ACK, SEND.
REQ-013 IDLE: if any ready flag is high, latch grant by round-robin and go to FETCH_X; otherwise stay.
REQ-014 Round-robin: search order starts at sensor after last served (acc->gyro->mag->acc); after reset, acc has highest priority.
REQ-015 Last-served pointer updates only on a completed SEND handshake.
REQ-016 FETCH_X/Y/Z: sensor_sel=grant, axis_sel=0/1/2; sensor_data captured into out_x/out_y/out_z at end of each state; advance unconditionally.
REQ-017 Outside FETCH states sensor_sel and axis_sel hold their last value.
REQ-018 ACK: assert exactly one read pulse (matching grant) for one cycle; go to SEND.
REQ-019 SEND: out_valid=1; out_id, out_x/y/z, out_seq stable while out_valid=1 and out_ready=0.
REQ-020 SEND with out_ready=1: transfer occurs that cycle; next cycle IDLE, out_valid=0, out_seq increments by 1 (wraps 255->0).
REQ-021 Ready flags are ignored in FETCH, ACK and SEND; no read pulse outside ACK.
REQ-022 Latency: ready first high in IDLE at edge n -> FETCH_X n+1, ACK n+4 (read pulse), out_valid from n+5.
REQ-023 Minimum packet period 6 cycles (IDLE one cycle between packets even with flags pending).
REQ-024 out_valid never depends combinationally on out_ready.

Reset
REQ-025 n_rst low at a rising edge: state=IDLE, out_valid=0, all read pulses 0, busy=0, sensor_sel=0, axis_sel=0, out_id=0, out_x/y/z=0, out_seq=0, pointer so acc has priority.
REQ-026 Reset mid-packet (any state) abandons the packet; no read pulse issued in or after the reset cycle; flag of the abandoned sensor stays set and is served after reset.

Verification
REQ-027 Single sensor: reset, gyro_ready=1, data X/Y/Z=0x1111/0x2222/0x3333 -> gyro_read pulse at n+4, out_valid at n+5 with out_id=1, axes as given, out_seq=0.
REQ-028 Backpressure: out_ready=0 for 10 cycles in SEND -> out_valid and all packet fields stable; out_ready=1 -> IDLE next cycle, out_seq=1.
REQ-029 Round-robin: all three flags held high, out_ready=1 -> packet ids 0,1,2,0,... each 6 cycles apart.
REQ-030 Fairness after service: serve mag, then acc and mag both ready -> acc served first.
REQ-031 Mid-fetch reset: n_rst low during FETCH_Y -> next cycle IDLE, no read pulse, out_valid=0; after release same sensor served with out_seq=0.
REQ-032 Sequence wrap: 256 consecutive packets -> out_seq 255 followed by 0.
